// File: rtl/dfe_reconfig_pkg.sv
// -----------------------------------------------------------------------------
// dfe_reconfig_pkg
// Shared definitions for the DFE reconfig sequencer:
//   - slave register map (ctrlstatus, chaddr, wdaddr, data)
//   - ctrlstatus bit positions
//   - sequencer FSM state type
//   - bit positions inside the {timeout, bad_channel, bad_word} error vector
//   - helper building the ctrlstatus "go" command word
// -----------------------------------------------------------------------------
package dfe_reconfig_pkg;

  // Slave register word addresses
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CH   = 2'd1;
  localparam logic [1:0] REG_WD   = 2'd2;
  localparam logic [1:0] REG_DATA = 2'd3;

  // ctrlstatus bit positions
  localparam int CS_START  = 0;
  localparam int CS_RD     = 1;
  localparam int CS_BAD_CH = 13;
  localparam int CS_BAD_WD = 14;
  localparam int CS_BUSY   = 15;

  // o_err bit positions
  localparam int ERR_BAD_WD  = 0;
  localparam int ERR_BAD_CH  = 1;
  localparam int ERR_TIMEOUT = 2;

  localparam int POLL_CNT_W = 8;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ARB    = 4'd1,
    S_WR_CH  = 4'd2,
    S_WR_WD  = 4'd3,
    S_WR_DAT = 4'd4,
    S_WR_GO  = 4'd5,
    S_POLL   = 4'd6,
    S_RD_DAT = 4'd7,
    S_DONE   = 4'd8
  } seq_state_e;

  // ctrlstatus command: start, plus rd for a read operation
  function automatic logic [15:0] go_cmd(input logic rd);
    logic [15:0] c;
    c           = '0;
    c[CS_START] = 1'b1;
    c[CS_RD]    = rd;
    return c;
  endfunction

endpackage

// File: rtl/dfe_reconfig_sequencer_arb.sv
// -----------------------------------------------------------------------------
// dfe_rr_arbiter
// Combinational round-robin winner select. Scans the request vector starting
// at the pointer and wraps; the first requester found wins. The pointer
// register itself lives in the parent.
// Ports:
//   i_req      request vector
//   i_ptr      index with highest priority this round
//   o_gnt_vld  at least one request present
//   o_gnt_idx  winner index
//   o_gnt_oh   winner one-hot
// -----------------------------------------------------------------------------
module dfe_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic               o_gnt_vld,
  output logic [PTR_W-1:0]   o_gnt_idx,
  output logic [NUM_REQ-1:0] o_gnt_oh
);

  always_comb begin
    int k;
    o_gnt_vld = 1'b0;
    o_gnt_idx = '0;
    o_gnt_oh  = '0;
    k         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // candidate index = (ptr + i) mod NUM_REQ
      k = int'(i_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!o_gnt_vld && i_req[k]) begin
        o_gnt_vld   = 1'b1;
        o_gnt_idx   = PTR_W'(k);
        o_gnt_oh[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dfe_reconfig_sequencer.sv
// -----------------------------------------------------------------------------
// dfe_reconfig_sequencer
// Avalon-MM master sharing one DFE reconfig register slave between NUM_REQ
// requesters. Each request is one DFE word read or write; the sequencer picks
// a winner round-robin, programs chaddr/wdaddr(/data), writes the go command,
// polls ctrlstatus until busy clears (or POLL_LIMIT polls), optionally reads
// back the data register and pulses o_done to the winner.
// Ports:
//   i_avmm_clk, i_resetn           clock, synchronous active-low reset
//   i_req/_rd/_ch/_wd/_wdata       per-requester request level and operands
//   o_done                         one-cycle completion pulse (one-hot)
//   o_rdata, o_err                 result, valid while o_done is high
//   o_busy                         sequence in progress
//   o_avmm_* / i_avmm_*            Avalon-MM master towards the DFE slave
// -----------------------------------------------------------------------------
module dfe_reconfig_sequencer
  import dfe_reconfig_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int CH_W       = 3,
  parameter int AVMM_AW    = 16,
  parameter int POLL_LIMIT = 255
) (
  input  logic                    i_avmm_clk,
  input  logic                    i_resetn,
  input  logic [NUM_REQ-1:0]      i_req,
  input  logic [NUM_REQ-1:0]      i_req_rd,
  input  logic [NUM_REQ*CH_W-1:0] i_req_ch,
  input  logic [NUM_REQ*2-1:0]    i_req_wd,
  input  logic [NUM_REQ*16-1:0]   i_req_wdata,
  output logic [NUM_REQ-1:0]      o_done,
  output logic [15:0]             o_rdata,
  output logic [2:0]              o_err,
  output logic                    o_busy,
  output logic [AVMM_AW-1:0]      o_avmm_maddress,
  output logic                    o_avmm_mread,
  output logic                    o_avmm_mwrite,
  output logic [15:0]             o_avmm_mwritedata,
  input  logic [15:0]             i_avmm_mreaddata,
  input  logic                    i_avmm_mwaitrequest
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Per-requester views of the flat operand buses
  logic [NUM_REQ-1:0][CH_W-1:0] req_ch;
  logic [NUM_REQ-1:0][1:0]      req_wd;
  logic [NUM_REQ-1:0][15:0]     req_wdata;

  assign req_ch    = i_req_ch;
  assign req_wd    = i_req_wd;
  assign req_wdata = i_req_wdata;

  // State and registered outputs
  seq_state_e              state_q,    state_d;
  logic [PTR_W-1:0]        ptr_q,      ptr_d;
  logic [PTR_W-1:0]        win_q,      win_d;
  logic [NUM_REQ-1:0]      win_oh_q,   win_oh_d;
  logic                    rd_q,       rd_d;
  logic [CH_W-1:0]         ch_q,       ch_d;
  logic [1:0]              wd_q,       wd_d;
  logic [15:0]             wdata_q,    wdata_d;
  logic [POLL_CNT_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic [2:0]              err_q,      err_d;
  logic [15:0]             rdata_q,    rdata_d;
  logic [NUM_REQ-1:0]      done_q,     done_d;
  logic [1:0]              addr_q,     addr_d;
  logic                    mread_q,    mread_d;
  logic                    mwrite_q,   mwrite_d;
  logic [15:0]             mwdata_q,   mwdata_d;

  logic                    gnt_vld;
  logic [PTR_W-1:0]        gnt_idx;
  logic [NUM_REQ-1:0]      gnt_oh;

  dfe_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .i_req     (i_req),
    .i_ptr     (ptr_q),
    .o_gnt_vld (gnt_vld),
    .o_gnt_idx (gnt_idx),
    .o_gnt_oh  (gnt_oh)
  );

  // A transfer completes in any cycle with a strobe up and no stall
  logic                  xfer_done;
  logic [POLL_CNT_W-1:0] poll_inc;
  logic                  st_busy;
  logic                  st_bad_ch;
  logic                  st_bad_wd;

  assign xfer_done = (mread_q | mwrite_q) & ~i_avmm_mwaitrequest;
  assign poll_inc  = poll_cnt_q + POLL_CNT_W'(1);
  assign st_busy   = i_avmm_mreaddata[CS_BUSY];
  assign st_bad_ch = i_avmm_mreaddata[CS_BAD_CH];
  assign st_bad_wd = i_avmm_mreaddata[CS_BAD_WD];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    win_oh_d   = win_oh_q;
    rd_d       = rd_q;
    ch_d       = ch_q;
    wd_d       = wd_q;
    wdata_d    = wdata_q;
    poll_cnt_d = poll_cnt_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    done_d     = '0;
    addr_d     = addr_q;
    mread_d    = mread_q;
    mwrite_d   = mwrite_q;
    mwdata_d   = mwdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (|i_req) state_d = S_ARB;
      end

      S_ARB: begin
        if (gnt_vld) begin
          // Snapshot the winner's operands; requester may change them later
          win_d      = gnt_idx;
          win_oh_d   = gnt_oh;
          rd_d       = i_req_rd[gnt_idx];
          ch_d       = req_ch[gnt_idx];
          wd_d       = req_wd[gnt_idx];
          wdata_d    = req_wdata[gnt_idx];
          poll_cnt_d = '0;
          err_d      = '0;
          rdata_d    = '0;
          addr_d     = REG_CH;
          mwrite_d   = 1'b1;
          mwdata_d   = 16'(req_ch[gnt_idx]);
          state_d    = S_WR_CH;
        end else begin
          // Request withdrawn between IDLE and ARB
          state_d = S_IDLE;
        end
      end

      S_WR_CH: begin
        if (xfer_done) begin
          addr_d   = REG_WD;
          mwdata_d = {14'b0, wd_q};
          state_d  = S_WR_WD;
        end
      end

      S_WR_WD: begin
        if (xfer_done) begin
          if (rd_q) begin
            addr_d   = REG_CTRL;
            mwdata_d = go_cmd(1'b1);
            state_d  = S_WR_GO;
          end else begin
            addr_d   = REG_DATA;
            mwdata_d = wdata_q;
            state_d  = S_WR_DAT;
          end
        end
      end

      S_WR_DAT: begin
        if (xfer_done) begin
          addr_d   = REG_CTRL;
          mwdata_d = go_cmd(1'b0);
          state_d  = S_WR_GO;
        end
      end

      S_WR_GO: begin
        if (xfer_done) begin
          mwrite_d = 1'b0;
          mwdata_d = '0;
          mread_d  = 1'b1;
          addr_d   = REG_CTRL;
          state_d  = S_POLL;
        end
      end

      S_POLL: begin
        if (xfer_done) begin
          poll_cnt_d = poll_inc;
          if (st_busy) begin
            if (poll_inc == POLL_CNT_W'(POLL_LIMIT)) begin
              err_d[ERR_TIMEOUT] = 1'b1;
              mread_d            = 1'b0;
              addr_d             = '0;
              done_d             = win_oh_q;
              state_d            = S_DONE;
            end
            // otherwise mread stays up: back-to-back re-poll
          end else begin
            err_d[ERR_BAD_CH] = st_bad_ch;
            err_d[ERR_BAD_WD] = st_bad_wd;
            if (rd_q && !st_bad_ch && !st_bad_wd) begin
              addr_d  = REG_DATA;
              state_d = S_RD_DAT;
            end else begin
              mread_d = 1'b0;
              addr_d  = '0;
              done_d  = win_oh_q;
              state_d = S_DONE;
            end
          end
        end
      end

      S_RD_DAT: begin
        if (xfer_done) begin
          rdata_d = i_avmm_mreaddata;
          mread_d = 1'b0;
          addr_d  = '0;
          done_d  = win_oh_q;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        ptr_d   = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_avmm_clk) begin
    if (!i_resetn) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      win_oh_q   <= '0;
      rd_q       <= 1'b0;
      ch_q       <= '0;
      wd_q       <= '0;
      wdata_q    <= '0;
      poll_cnt_q <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
      done_q     <= '0;
      addr_q     <= '0;
      mread_q    <= 1'b0;
      mwrite_q   <= 1'b0;
      mwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      win_oh_q   <= win_oh_d;
      rd_q       <= rd_d;
      ch_q       <= ch_d;
      wd_q       <= wd_d;
      wdata_q    <= wdata_d;
      poll_cnt_q <= poll_cnt_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      addr_q     <= addr_d;
      mread_q    <= mread_d;
      mwrite_q   <= mwrite_d;
      mwdata_q   <= mwdata_d;
    end
  end

  assign o_done            = done_q;
  assign o_rdata           = rdata_q;
  assign o_err             = err_q;
  assign o_busy            = (state_q != S_IDLE);
  assign o_avmm_maddress   = {{(AVMM_AW-2){1'b0}}, addr_q};
  assign o_avmm_mread      = mread_q;
  assign o_avmm_mwrite     = mwrite_q;
  assign o_avmm_mwritedata = mwdata_q;

endmodule
